adc_trig_recorder: RTL

Triggered capture controller for the AD9284 acquisition path. It sits directly downstream of the LVDS/IDDR capture stage and consumes that stage's 64-bit `wr_data` word (8 unsigned offset-binary 8-bit samples) once per `dclk` cycle. It maintains a circular pre-trigger history, detects a level-crossing or forced trigger, and records a post-trigger window through a simple-dual-port BRAM write port. The host reads the memory back on the other BRAM port after `done`.

---
 rtl/adc_trig_recorder_pkg.sv | 18 +
 rtl/adc_level_detect.sv | 34 +++
 rtl/adc_trig_recorder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/adc_trig_recorder_pkg.sv
// Shared types and constants for the AD9284 triggered capture recorder.
// A capture word carries NUM_LANES offset-binary samples of LANE_W bits each.
package adc_trig_recorder_pkg;

   localparam int ADDR_W_DEF = 10;
   localparam int NUM_LANES  = 8;
   localparam int LANE_W     = 8;
   localparam int WORD_W     = NUM_LANES * LANE_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_WAIT,
      ST_POST,
      ST_DONE
   } state_e;

endpackage

// File: rtl/adc_level_detect.sv
// Per-word level detector: a word is "above" when any lane reaches the threshold;
// hit is a registered rising edge of that flag at word granularity.
module adc_level_detect
   import adc_trig_recorder_pkg::*;
(
   input  logic                                dclk,
   input  logic                                rst,
   input  logic [NUM_LANES-1:0][LANE_W-1:0]    din,
   input  logic [LANE_W-1:0]                   trig_level,
   output logic                                hit
);

   logic [NUM_LANES-1:0] lane_ge;
   logic                 above;
   logic                 above_prev;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      assign lane_ge[g] = (din[g] >= trig_level);
   end

   assign above = |lane_ge;

   // History starts high so the first word after reset can never look like an edge.
   always_ff @(posedge dclk or posedge rst) begin
      if (rst) begin
         above_prev <= 1'b1;
         hit        <= 1'b0;
      end else begin
         above_prev <= above;
         hit        <= above & ~above_prev;
      end
   end

endmodule

// File: rtl/adc_trig_recorder.sv
// Triggered capture controller: circular pre-trigger history, level/forced trigger,
// bounded post-trigger window, written through a BRAM write port two cycles after din.
module adc_trig_recorder
   import adc_trig_recorder_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              dclk,
   input  logic              rst,
   input  logic [WORD_W-1:0] din,
   input  logic              arm,
   input  logic              abort,
   input  logic              force_trig,
   input  logic [LANE_W-1:0] trig_level,
   input  logic [ADDR_W-1:0] pre_len,
   input  logic [ADDR_W-1:0] post_len,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] trig_addr
);

   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   state_e            state, state_nx;
   logic [WORD_W-1:0] din_q;
   logic              hit_q;
   logic [ADDR_W-1:0] wr_ptr, fill_cnt, post_cnt, pre_q, post_q;
   logic [ADDR_W-1:0] post_room, post_clamp;
   logic              pre_full, post_full, trig_req;
   logic              in_acq, start, wr_en, trig_fire, busy_nx, done_nx;

   // DEPTH-1-pre_len is the bitwise complement of pre_len in ADDR_W bits.
   assign post_room  = ~pre_len;
   assign post_clamp = (post_len < post_room) ? post_len : post_room;

   assign pre_full  = (pre_q == '0) || ((fill_cnt + ONE) == pre_q);
   assign post_full = ((post_cnt + ONE) == post_q);
   assign trig_req  = hit_q | force_trig;

   adc_level_detect u_level (
      .dclk       (dclk),
      .rst        (rst),
      .din        (din),
      .trig_level (trig_level),
      .hit        (hit_q)
   );

   // Stage 1: hold the word alongside its registered hit flag.
   always_ff @(posedge dclk or posedge rst) begin
      if (rst) din_q <= '0;
      else     din_q <= din;
   end

   always_ff @(posedge dclk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE, ST_DONE: if (arm) state_nx = ST_PRE;
         ST_PRE:           if (pre_full) state_nx = ST_WAIT;
         ST_WAIT:          if (trig_req) state_nx = (post_q == '0) ? ST_DONE : ST_POST;
         ST_POST:          if (post_full) state_nx = ST_DONE;
         default:          state_nx = ST_IDLE;
      endcase
      if (abort) state_nx = ST_IDLE;
   end

   always_comb begin
      in_acq    = (state == ST_PRE) || (state == ST_WAIT) || (state == ST_POST);
      start     = arm && !abort && ((state == ST_IDLE) || (state == ST_DONE));
      wr_en     = in_acq && !abort;
      trig_fire = (state == ST_WAIT) && trig_req && !abort;
      busy_nx   = (state_nx == ST_PRE) || (state_nx == ST_WAIT) || (state_nx == ST_POST);
      // done trails the state by one cycle so it rises exactly as mem_we falls.
      done_nx   = (state == ST_DONE) && !abort && !arm;
   end

   // Stage 2: write port, counters and status, all registered.
   always_ff @(posedge dclk or posedge rst) begin
      if (rst) begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         trig_addr <= '0;
         wr_ptr    <= '0;
         fill_cnt  <= '0;
         post_cnt  <= '0;
         pre_q     <= '0;
         post_q    <= '0;
      end else begin
         mem_we <= wr_en;
         busy   <= busy_nx;
         done   <= done_nx;
         if (start) begin
            pre_q    <= pre_len;
            post_q   <= post_clamp;
            wr_ptr   <= '0;
            fill_cnt <= '0;
            post_cnt <= '0;
            mem_addr <= '0;
         end
         if (wr_en) begin
            mem_addr  <= wr_ptr;
            mem_wdata <= din_q;
            wr_ptr    <= wr_ptr + ONE;
         end
         if (wr_en && (state == ST_PRE))  fill_cnt <= fill_cnt + ONE;
         if (wr_en && (state == ST_POST)) post_cnt <= post_cnt + ONE;
         if (trig_fire)                   trig_addr <= wr_ptr;
      end
   end

endmodule
